// File: rtl/ptp_pkg.sv
// ptp_pkg: shared constants, register offsets and types for the PTP time-of-day register block.
package ptp_pkg;

   localparam logic [29:0] NS_PER_SEC = 30'd1_000_000_000;

   localparam logic [7:0] REG_ID       = 8'h00;
   localparam logic [7:0] REG_CTRL     = 8'h04;
   localparam logic [7:0] REG_INC      = 8'h08;
   localparam logic [7:0] REG_TOD_NS   = 8'h0C;
   localparam logic [7:0] REG_TOD_SEC  = 8'h10;
   localparam logic [7:0] REG_LOAD_NS  = 8'h14;
   localparam logic [7:0] REG_LOAD_SEC = 8'h18;
   localparam logic [7:0] REG_ADJ      = 8'h1C;
   localparam logic [7:0] REG_SCRATCH  = 8'h20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } cpu_state_e;

   typedef struct packed {
      logic [31:0] sec;
      logic [29:0] ns;
   } tod_t;

endpackage

// File: rtl/ptp_tod_cpu_regs_if.sv
// ptp_tod_cpu_regs_if: single-cycle cpu_if request/response bus on the h_clk side.
interface ptp_tod_cpu_regs_if;
   logic        read;
   logic        write;
   logic [31:0] write_data;
   logic [31:2] address;
   logic [31:0] read_data;
   logic        access_complete;

   modport master (output read, write, write_data, address,
                   input  read_data, access_complete);
   modport slave  (input  read, write, write_data, address,
                   output read_data, access_complete);
endinterface

// File: rtl/ptp_tod_counter.sv
// ptp_tod_counter: seconds/nanoseconds time-of-day counter with load, increment and one-shot adjust.
module ptp_tod_counter
   import ptp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [7:0]  inc,
   input  logic        load,
   input  tod_t        load_val,
   input  logic        adj_wr,
   input  logic [31:0] adj_val,
   output tod_t        tod,
   output logic        pps
);
   localparam logic signed [32:0] NS_SEC_S = $signed({3'b000, NS_PER_SEC});

   tod_t               tod_q, tod_d;
   logic               pps_q, pps_d;
   logic               adj_pend_q, adj_pend_d;
   logic [31:0]        adj_q, adj_d;
   logic signed [32:0] adj_ext;
   logic signed [32:0] t;

   always_comb begin
      tod_d      = tod_q;
      pps_d      = 1'b0;
      adj_pend_d = adj_pend_q;
      adj_d      = adj_q;
      adj_ext    = adj_pend_q ? $signed({adj_q[31], adj_q}) : 33'sd0;
      t          = $signed({3'b000, tod_q.ns}) + $signed({25'd0, inc}) + adj_ext;
      if (enable) begin
         adj_pend_d = 1'b0;
         if (t >= NS_SEC_S) begin
            tod_d.ns  = 30'(t - NS_SEC_S);
            tod_d.sec = tod_q.sec + 32'd1;
            pps_d     = 1'b1;
         end else if (t[32]) begin
            tod_d.ns  = 30'(t + NS_SEC_S);
            tod_d.sec = tod_q.sec - 32'd1;
         end else begin
            tod_d.ns  = t[29:0];
         end
      end
      if (adj_wr) begin
         adj_pend_d = 1'b1;
         adj_d      = adj_val;
      end
      // a load overrides both the step and any adjust, pending or fresh
      if (load) begin
         tod_d.sec  = load_val.sec;
         tod_d.ns   = (load_val.ns >= NS_PER_SEC) ? NS_PER_SEC - 30'd1 : load_val.ns;
         pps_d      = 1'b0;
         adj_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tod_q      <= '0;
         pps_q      <= 1'b0;
         adj_pend_q <= 1'b0;
         adj_q      <= '0;
      end else begin
         tod_q      <= tod_d;
         pps_q      <= pps_d;
         adj_pend_q <= adj_pend_d;
         adj_q      <= adj_d;
      end
   end

   assign tod = tod_q;
   assign pps = pps_q;

endmodule

// File: rtl/ptp_tod_cpu_regs.sv
// ptp_tod_cpu_regs: cpu_if responder exposing the PTP time-of-day counter registers.
// state | meaning
// IDLE  | waiting for a read/write request; captures it
// WAIT  | counting down the configured wait states
// RESP  | one-cycle access_complete; register writes take effect
module ptp_tod_cpu_regs
   import ptp_pkg::*;
#(
   parameter logic [23:0] BASE_ADDR   = 24'h000000,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [7:0]  NS_PER_CLK  = 8'd8,
   parameter logic [31:0] ID_VALUE    = 32'h5054_0100
) (
   input  logic              h_clk,
   input  logic              h_reset_n,
   ptp_tod_cpu_regs_if.slave h_cpu_if,
   output logic [31:0]       tod_sec,
   output logic [29:0]       tod_ns,
   output logic              pps
);
   localparam logic [2:0] WS_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

   cpu_state_e  state_q, state_d;
   logic [2:0]  wcnt_q, wcnt_d;
   logic        wr_q, wr_d, rd_q, rd_d, hit_q, hit_d;
   logic [7:0]  off_q, off_d;
   logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, shadow_q, shadow_d;
   logic [31:0] scratch_q, scratch_d, load_sec_q, load_sec_d;
   logic        enable_q, enable_d;
   logic [7:0]  inc_q, inc_d;
   logic [29:0] load_ns_q, load_ns_d;

   logic        req, cur_hit, cur_rd, access_complete, reg_we, load_pulse, adj_wr;
   logic [7:0]  cur_off;
   logic [31:0] rd_mux;
   tod_t        tod, load_val;

   assign req = h_cpu_if.read | h_cpu_if.write;

   always_ff @(posedge h_clk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: if (req) begin
            if (WAIT_STATES == 0) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
               wcnt_d  = WS_LOAD;
            end
         end
         WAIT: if (wcnt_q == 3'd0) state_d = RESP;
               else wcnt_d = wcnt_q - 3'd1;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      access_complete = 1'b0;
      reg_we          = 1'b0;
      if (state_q == RESP) begin
         access_complete = 1'b1;
         reg_we          = wr_q & hit_q;
      end
      load_pulse = reg_we & (off_q == REG_CTRL) & wdata_q[1];
      adj_wr     = reg_we & (off_q == REG_ADJ);
   end

   always_comb begin
      wr_d = wr_q; rd_d = rd_q; hit_d = hit_q; off_d = off_q; wdata_d = wdata_q;
      cur_hit = hit_q;
      cur_off = off_q;
      cur_rd  = rd_q;
      // in IDLE the live bus is the request; for zero wait states RESP follows immediately
      if (state_q == IDLE) begin
         cur_hit = (h_cpu_if.address[31:8] == BASE_ADDR);
         cur_off = {h_cpu_if.address[7:2], 2'b00};
         cur_rd  = h_cpu_if.read & ~h_cpu_if.write;
         if (req) begin
            wr_d    = h_cpu_if.write;
            rd_d    = cur_rd;
            hit_d   = cur_hit;
            off_d   = cur_off;
            wdata_d = h_cpu_if.write_data;
         end
      end

      rd_mux = 32'd0;
      case (cur_off)
         REG_ID:       rd_mux = ID_VALUE;
         REG_CTRL:     rd_mux = {31'd0, enable_q};
         REG_INC:      rd_mux = {24'd0, inc_q};
         REG_TOD_NS:   rd_mux = {2'b00, tod.ns};
         REG_TOD_SEC:  rd_mux = shadow_q;
         REG_LOAD_NS:  rd_mux = {2'b00, load_ns_q};
         REG_LOAD_SEC: rd_mux = load_sec_q;
         REG_SCRATCH:  rd_mux = scratch_q;
         default:      rd_mux = 32'd0;
      endcase

      rdata_d  = rdata_q;
      shadow_d = shadow_q;
      if (state_d == RESP && state_q != RESP) begin
         rdata_d = (cur_rd && cur_hit) ? rd_mux : 32'd0;
         if (cur_rd && cur_hit && cur_off == REG_TOD_NS) shadow_d = tod.sec;
      end

      enable_d = enable_q; inc_d = inc_q; load_ns_d = load_ns_q;
      load_sec_d = load_sec_q; scratch_d = scratch_q;
      if (reg_we) begin
         case (off_q)
            REG_CTRL:     enable_d   = wdata_q[0];
            REG_INC:      inc_d      = wdata_q[7:0];
            REG_LOAD_NS:  load_ns_d  = wdata_q[29:0];
            REG_LOAD_SEC: load_sec_d = wdata_q;
            REG_SCRATCH:  scratch_d  = wdata_q;
            default:      ;
         endcase
      end
   end

   always_ff @(posedge h_clk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         wr_q <= 1'b0; rd_q <= 1'b0; hit_q <= 1'b0; off_q <= '0; wdata_q <= '0;
         rdata_q <= '0; shadow_q <= '0; enable_q <= 1'b0; inc_q <= NS_PER_CLK;
         load_ns_q <= '0; load_sec_q <= '0; scratch_q <= '0;
      end else begin
         wr_q <= wr_d; rd_q <= rd_d; hit_q <= hit_d; off_q <= off_d; wdata_q <= wdata_d;
         rdata_q <= rdata_d; shadow_q <= shadow_d; enable_q <= enable_d; inc_q <= inc_d;
         load_ns_q <= load_ns_d; load_sec_q <= load_sec_d; scratch_q <= scratch_d;
      end
   end

   assign load_val = {load_sec_q, load_ns_q};

   ptp_tod_counter u_counter (
      .clk      (h_clk),
      .rst_n    (h_reset_n),
      .enable   (enable_q),
      .inc      (inc_q),
      .load     (load_pulse),
      .load_val (load_val),
      .adj_wr   (adj_wr),
      .adj_val  (wdata_q),
      .tod      (tod),
      .pps      (pps)
   );

   assign h_cpu_if.read_data       = rdata_q;
   assign h_cpu_if.access_complete = access_complete;
   assign tod_sec                  = tod.sec;
   assign tod_ns                   = tod.ns;

   a_req_only_in_idle: assert property (@(posedge h_clk) disable iff (!h_reset_n)
      req |-> (state_q == IDLE));

endmodule

// File: tb/tb_ptp_tod_cpu_regs.sv
// Scoreboard bench for ptp_tod_cpu_regs: one instance with no wait states, one with three.
module tb_ptp_tod_cpu_regs;
   import ptp_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_n_s [2];
   logic        rd_s    [2];
   logic        wr_s    [2];
   logic [31:0] wd_s    [2];
   logic [31:2] ad_s    [2];
   logic [31:0] rdat_s  [2];
   logic        ac_s    [2];
   logic [31:0] sec_s   [2];
   logic [29:0] ns_s    [2];
   logic        pps_s   [2];

   logic [31:0] sec0, sec3;
   logic [29:0] ns0, ns3;
   logic        pps0, pps3;

   ptp_tod_cpu_regs_if bus0 ();
   ptp_tod_cpu_regs_if bus3 ();

   assign bus0.read = rd_s[0];  assign bus0.write = wr_s[0];
   assign bus0.write_data = wd_s[0];  assign bus0.address = ad_s[0];
   assign bus3.read = rd_s[1];  assign bus3.write = wr_s[1];
   assign bus3.write_data = wd_s[1];  assign bus3.address = ad_s[1];
   assign rdat_s[0] = bus0.read_data;  assign ac_s[0] = bus0.access_complete;
   assign rdat_s[1] = bus3.read_data;  assign ac_s[1] = bus3.access_complete;
   assign sec_s[0] = sec0;  assign ns_s[0] = ns0;  assign pps_s[0] = pps0;
   assign sec_s[1] = sec3;  assign ns_s[1] = ns3;  assign pps_s[1] = pps3;

   ptp_tod_cpu_regs #(.WAIT_STATES(0)) u_dut0 (
      .h_clk(clk), .h_reset_n(rst_n_s[0]), .h_cpu_if(bus0),
      .tod_sec(sec0), .tod_ns(ns0), .pps(pps0));

   ptp_tod_cpu_regs #(.WAIT_STATES(3)) u_dut3 (
      .h_clk(clk), .h_reset_n(rst_n_s[1]), .h_cpu_if(bus3),
      .tod_sec(sec3), .tod_ns(ns3), .pps(pps3));

   typedef struct {
      int          dut;
      bit          chk;
      logic [31:0] data;
      int          lat;
      int          req_cyc;
      string       nm;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   done_cyc = 0;
   int   ref_cyc = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   exp_t me;
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (ac_s[d] === 1'b1) begin
            if (sb.size() == 0 || sb[0].dut != d) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_complete dut%0d: got access_complete=1 required 0 (cycle %0d)", d, cyc);
            end else begin
               me = sb.pop_front();
               check($sformatf("%s_latency", me.nm), 64'(cyc - me.req_cyc), 64'(me.lat));
               if (me.chk) check($sformatf("%s_rdata", me.nm), 64'(rdat_s[d]), 64'(me.data));
               done_cyc = cyc;
            end
         end
      end
   end

   // slope != 0 makes the expected read value track a running counter from ref_cyc
   task automatic access(input int d, input bit w, input bit r, input logic [31:0] addr,
                         input logic [31:0] data, input bit chk_rd, input logic [31:0] exp,
                         input int slope, input string nm);
      exp_t e;
      @(posedge clk); #1;
      e.dut = d; e.chk = chk_rd; e.lat = (d == 0) ? 1 : 4; e.req_cyc = cyc; e.nm = nm;
      e.data = exp + 32'(slope * (cyc - ref_cyc));
      sb.push_back(e);
      rd_s[d] = r; wr_s[d] = w; ad_s[d] = addr[31:2]; wd_s[d] = data;
      @(posedge clk); #1;
      rd_s[d] = 1'b0; wr_s[d] = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout: got no access_complete required one within 20 cycles", nm);
         sb.delete();
      end
   endtask

   task automatic wr(input int d, input logic [7:0] off, input logic [31:0] data, input string nm);
      access(d, 1'b1, 1'b0, 32'(off), data, 1'b0, 32'd0, 0, nm);
   endtask

   task automatic rd(input int d, input logic [31:0] addr, input logic [31:0] exp, input string nm);
      access(d, 1'b0, 1'b1, addr, 32'd0, 1'b1, exp, 0, nm);
   endtask

   task automatic at_cyc(input int c);
      for (int i = 0; i < 1000 && cyc < c; i++) @(negedge clk);
   endtask

   task automatic check_tod(input int d, input string nm, input logic [31:0] sec,
                            input logic [29:0] ns, input logic p);
      check({nm, "_sec"}, 64'(sec_s[d]), 64'(sec));
      check({nm, "_ns"},  64'(ns_s[d]),  64'(ns));
      check({nm, "_pps"}, 64'(pps_s[d]), 64'(p));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r_cyc;
      int pcnt;
      int seen;
      for (int d = 0; d < 2; d++) begin
         rst_n_s[d] = 1'b0; rd_s[d] = 1'b0; wr_s[d] = 1'b0; wd_s[d] = '0; ad_s[d] = '0;
      end
      repeat (3) @(negedge clk);
      check("rst_rdata", 64'(rdat_s[0]), 64'd0);
      check("rst_ac", 64'(ac_s[0]), 64'd0);
      check_tod(0, "rst", 32'd0, 30'd0, 1'b0);
      rst_n_s[0] = 1'b1;
      rst_n_s[1] = 1'b1;

      rd(0, 32'(REG_ID), 32'h5054_0100, "id");
      repeat (3) @(negedge clk);
      check("rdata_held", 64'(rdat_s[0]), 64'h5054_0100);
      rd(0, 32'(REG_INC), 32'd8, "inc_reset");
      rd(0, 32'h0000_0100, 32'd0, "base_mismatch");

      wr(0, REG_INC, 32'd8, "wr_inc");
      wr(0, REG_LOAD_NS, 32'd999_999_990, "wr_load_ns");
      wr(0, REG_LOAD_SEC, 32'd5, "wr_load_sec");
      wr(0, REG_CTRL, 32'd3, "wr_ctrl_load_en");
      r_cyc = done_cyc;
      pcnt = 0;
      for (int c = r_cyc + 1; c <= r_cyc + 4; c++) begin
         at_cyc(c);
         if (pps_s[0] === 1'b1) pcnt++;
         if (c == r_cyc + 1) check_tod(0, "after_load", 32'd5, 30'd999_999_990, 1'b0);
         if (c == r_cyc + 3) check_tod(0, "wrap", 32'd6, 30'd6, 1'b1);
      end
      check("wrap_pps_count", 64'(pcnt), 64'd1);
      ref_cyc = r_cyc + 3;
      rd(0, 32'(REG_CTRL), 32'd1, "ctrl_load_selfclear");

      access(0, 1'b0, 1'b1, 32'(REG_TOD_NS), 32'd0, 1'b1, 32'd6, 8, "tod_ns");
      repeat (100) @(posedge clk);
      @(negedge clk);
      check("live_sec_after_100", 64'(sec_s[0]), 64'd6);
      wr(0, REG_LOAD_SEC, 32'd10, "wr_load_sec10");
      wr(0, REG_LOAD_NS, 32'd5, "wr_load_ns5");
      wr(0, REG_CTRL, 32'd2, "wr_ctrl_load_dis");
      rd(0, 32'(REG_TOD_SEC), 32'd6, "shadow_sec");
      check_tod(0, "loaded_disabled", 32'd10, 30'd5, 1'b0);

      wr(0, REG_ADJ, 32'hFFFF_FFEC, "wr_adj_m20");
      rd(0, 32'(REG_ADJ), 32'd0, "adj_reads0");
      check("adj_pending_held_ns", 64'(ns_s[0]), 64'd5);
      wr(0, REG_CTRL, 32'd1, "wr_ctrl_en");
      r_cyc = done_cyc;
      at_cyc(r_cyc + 2);
      check_tod(0, "adj_borrow", 32'd9, 30'd999_999_993, 1'b0);
      at_cyc(r_cyc + 3);
      check_tod(0, "adj_oneshot", 32'd10, 30'd1, 1'b1);

      wr(0, REG_LOAD_NS, 32'h3FFF_FFFF, "wr_load_ns_big");
      wr(0, REG_CTRL, 32'd2, "wr_ctrl_clamp");
      at_cyc(done_cyc + 1);
      check("load_clamp_ns", 64'(ns_s[0]), 64'd999_999_999);
      rd(0, 32'(REG_LOAD_NS), 32'h3FFF_FFFF, "load_ns_raw");

      access(0, 1'b1, 1'b1, 32'(REG_SCRATCH), 32'h1234_5678, 1'b1, 32'd0, 0, "rw_both");
      rd(0, 32'(REG_SCRATCH), 32'h1234_5678, "rw_both_written");

      wr(1, REG_LOAD_SEC, 32'd7, "d3_load_sec");
      wr(1, REG_CTRL, 32'd3, "d3_ctrl");
      wr(1, REG_SCRATCH, 32'hA5A5_1234, "d3_scratch_wr");
      rd(1, 32'h0000_003C, 32'd0, "d3_unmapped");
      rd(1, 32'(REG_SCRATCH), 32'hA5A5_1234, "d3_scratch_rd");
      check("d3_running_sec", 64'(sec_s[1]), 64'd7);

      @(posedge clk); #1;
      rd_s[1] = 1'b1; ad_s[1] = '0;
      @(posedge clk); #1;
      rd_s[1] = 1'b0;
      @(posedge clk); #1;
      rst_n_s[1] = 1'b0;
      @(negedge clk);
      check("d3_rst_rdata", 64'(rdat_s[1]), 64'd0);
      check("d3_rst_ac", 64'(ac_s[1]), 64'd0);
      check_tod(1, "d3_rst", 32'd0, 30'd0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n_s[1] = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (ac_s[1] === 1'b1) seen++;
      end
      check("d3_no_complete_after_rst", 64'(seen), 64'd0);
      rd(1, 32'(REG_ID), 32'h5054_0100, "d3_id_after_rst");
      rd(1, 32'(REG_SCRATCH), 32'd0, "d3_scratch_cleared");

      repeat (2) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
